bcd_to_binary: RTL and testbench

Sequential three-digit BCD-to-binary converter using the reverse double-dabble (shift-right, subtract-3) algorithm. It is the inverse of the display path's binary-to-BCD stage. It takes hundreds, tens and ones digits, for example from keypad or LCD entry, and returns a 10-bit binary value for arithmetic logic. One conversion is accepted per start pulse. A fixed 10-iteration shift loop produces the result, which is reported with a one-cycle `done` pulse.

---
 rtl/bcd_to_binary.sv | 122 ++++++++++++
 tb/tb_bcd_to_binary.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 10-bit binary converter, reverse double-dabble (shift right, subtract 3).
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] H,
  input  logic [3:0] T,
  input  logic [3:0] O,
  output logic [9:0] binary_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [21:0] work_q, work_d;
  logic [21:0] shifted;
  logic [9:0]  bin_q, bin_d;
  logic        busy_q;
  logic        done_q, done_d;

  // After the right shift, a nibble >= 8 received a carried-in 8 that is really a 5.
  function automatic logic [3:0] fix_nibble(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic inv_q, inv_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
    shifted = work_q >> 1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    inv_d   = inv_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = {H, T, O, 10'b0};
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          inv_d   = (H > 4'd9) || (T > 4'd9) || (O > 4'd9);
`endif
        end
      end
      S_SHIFT: begin
        work_d = {fix_nibble(shifted[21:18]), fix_nibble(shifted[17:14]),
                  fix_nibble(shifted[13:10]), shifted[9:0]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        bin_d   = work_q[9:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d   = inv_q;
        if (inv_q) begin
          bin_d = '1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bin_q   <= bin_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign binary_out = bin_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary; expected results queued at start, compared at done.
// Invalid-digit cases are exercised only when BCD2BIN_DIGIT_CHECK_EN is defined.
module tb_bcd_to_binary;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] H, T, O;
  logic [9:0] binary_out;
  logic       busy, done, err;

  int checks;
  int failures;
  int cyc;
  int done_cnt;
  logic [10:0] sb[$];

  bcd_to_binary dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .H         (H),
    .T         (T),
    .O         (O),
    .binary_out(binary_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      bit have;
      logic [10:0] e;
      done_cnt++;
      have = (sb.size() != 0);
      check("done_expected", int'(have), 1);
      if (have) begin
        e = sb.pop_front();
        check("binary_out", int'(binary_out), int'(e[9:0]));
        check("err", int'(err), int'(e[10]));
      end
    end
  end

  task automatic drive_start(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                             input bit push, input bit exp_err, output int sc);
    logic [9:0] v;
    H = h; T = t; O = o;
    start = 1'b1;
    if (push) begin
      v = exp_err ? 10'h3FF : 10'(100 * int'(h) + 10 * int'(t) + int'(o));
      sb.push_back({exp_err, v});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    sc = cyc;
  endtask

  // Waits (bounded) for the done cycle; returns its cycle number and busy-cycle count.
  task automatic wait_done(input int sc, output int dc, output int bcnt);
    int n;
    bit seen;
    n = 0; bcnt = 0; seen = 0; dc = -1;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        dc = cyc;
        check("busy_low_at_done", int'(busy), 0);
      end else if (busy) begin
        bcnt++;
      end
    end
    check("done_seen", int'(seen), 1);
    if (seen) check("latency", dc - sc, 11);
  endtask

  task automatic conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                      input bit exp_err);
    int sc, dc, bc;
    @(negedge clk);
    drive_start(h, t, o, 1'b1, exp_err, sc);
    wait_done(sc, dc, bc);
    check("busy_cycles", bc, 11);
  endtask

  initial begin
    int sc, dc, bc, dc1, dcnt0;
    checks = 0; failures = 0; cyc = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; H = '0; T = '0; O = '0;
    repeat (3) @(negedge clk);
    check("rst_binary_out", int'(binary_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;

    conv(4'd0, 4'd0, 4'd0, 1'b0);

    // 999 plus single-cycle done width
    conv(4'd9, 4'd9, 4'd9, 1'b0);
    @(negedge clk);
    check("done_width", int'(done), 0);
    check("hold_after_done", int'(binary_out), 999);

    // back-to-back: second start issued in the done cycle
    @(negedge clk);
    drive_start(4'd2, 4'd5, 4'd5, 1'b1, 1'b0, sc);
    wait_done(sc, dc1, bc);
    drive_start(4'd7, 4'd0, 4'd5, 1'b1, 1'b0, sc);
    wait_done(sc, dc, bc);
    check("b2b_spacing", dc - dc1, 12);
    check("b2b_busy", bc, 11);

    // start re-pulse and digit change mid-conversion are ignored
    @(negedge clk);
    dcnt0 = done_cnt;
    drive_start(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, sc);
    repeat (4) @(negedge clk);
    drive_start(4'd4, 4'd5, 4'd6, 1'b0, 1'b0, bc);
    wait_done(sc, dc, bc);
    repeat (15) @(negedge clk);
    check("single_done", done_cnt - dcnt0, 1);

    // reset mid-conversion aborts it
    dcnt0 = done_cnt;
    drive_start(4'd4, 4'd5, 4'd6, 1'b0, 1'b0, sc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_binary_out", int'(binary_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - dcnt0, 0);
    conv(4'd4, 4'd5, 4'd6, 1'b0);

    // reset and start on the same edge: start dropped
    @(negedge clk);
    dcnt0 = done_cnt;
    rst_n = 1'b0; start = 1'b1; H = 4'd3; T = 4'd3; O = 4'd3;
    @(posedge clk);
    #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", int'(busy), 0);
    repeat (15) @(negedge clk);
    check("rst_start_no_done", done_cnt - dcnt0, 0);

    for (int i = 0; i < 6; i++) begin
      conv(4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9)), 1'b0);
    end
    conv(4'd1, 4'd0, 4'd0, 1'b0);
    conv(4'd0, 4'd0, 4'd9, 1'b0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    conv(4'hA, 4'd0, 4'd0, 1'b1);
    conv(4'd0, 4'd4, 4'd2, 1'b0);
    conv(4'd1, 4'hF, 4'd3, 1'b1);
    conv(4'd9, 4'd9, 4'd9, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
